// File: rtl/wb_stage_ctrl.sv
// rtl/wb_stage_ctrl.sv - write-back stage: load formatting, 2-entry result queue, register-file write port, retire counter (optional bypass: WB_STAGE_CTRL_BYPASS_EN)
module wb_stage_ctrl #(
    parameter int XLEN         = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int RETIRE_CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_wb_en,
    input  logic [REG_ADDR_W-1:0]   in_rd,
    input  logic [1:0]              in_wb_sel,
    input  logic [1:0]              in_mem_size,
    input  logic                    in_mem_unsigned,
    input  logic [2:0]              in_addr_lo,
    input  logic [XLEN-1:0]         in_mem_data,
    input  logic [XLEN-1:0]         in_alu_result,
    input  logic [XLEN-1:0]         in_pc_plus4,
    output logic                    rf_we,
    output logic [REG_ADDR_W-1:0]   rf_waddr,
    output logic [XLEN-1:0]         rf_wdata,
    input  logic                    rf_wr_ready,
    output logic [RETIRE_CNT_W-1:0] retire_count
`ifdef WB_STAGE_CTRL_BYPASS_EN
    ,
    output logic                    byp_valid,
    output logic [REG_ADDR_W-1:0]   byp_rd,
    output logic [XLEN-1:0]         byp_data
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic                    r_in_ready;
    logic                    r_head_we;
    logic [REG_ADDR_W-1:0]   r_head_rd;
    logic [XLEN-1:0]         r_head_data;
    logic                    r_tail_we;
    logic [REG_ADDR_W-1:0]   r_tail_rd;
    logic [XLEN-1:0]         r_tail_data;
    logic [RETIRE_CNT_W-1:0] r_retire_cnt;

    logic [2:0]              w_lane;
    logic [XLEN-1:0]         w_shifted;
    logic [XLEN-1:0]         w_keep_mask;
    logic                    w_sign;
    logic [XLEN-1:0]         w_load_val;
    logic [XLEN-1:0]         w_wb_val;
    logic                    w_new_we;
    logic                    w_head_valid;
    logic                    w_push;
    logic                    w_pop;

    // Pick the aligned byte lane for the access size; unused low address bits truncate the access down
    always_comb begin
        w_lane = in_addr_lo;
        if (XLEN == 32) begin
            w_lane[2] = 1'b0;
        end
        case (in_mem_size)
            2'b00:   w_lane = w_lane;
            2'b01:   w_lane[0] = 1'b0;
            2'b10:   w_lane[1:0] = 2'b00;
            default: begin
                if (XLEN == 64) begin
                    w_lane = 3'b000;
                end else begin
                    w_lane[1:0] = 2'b00;
                end
            end
        endcase
    end

    assign w_shifted = in_mem_data >> {w_lane, 3'b000};

    // Keep only the accessed bytes and find the sign bit of the access
    always_comb begin
        w_keep_mask = '1;
        w_sign      = w_shifted[XLEN-1];
        case (in_mem_size)
            2'b00: begin
                w_keep_mask = XLEN'(8'hFF);
                w_sign      = w_shifted[7];
            end
            2'b01: begin
                w_keep_mask = XLEN'(16'hFFFF);
                w_sign      = w_shifted[15];
            end
            2'b10: begin
                w_keep_mask = XLEN'(32'hFFFF_FFFF);
                w_sign      = w_shifted[31];
            end
            default: begin
                w_keep_mask = '1;
                w_sign      = w_shifted[XLEN-1];
            end
        endcase
    end

    assign w_load_val = (w_shifted & w_keep_mask) |
                        ((w_sign && !in_mem_unsigned) ? ~w_keep_mask : '0);

    // Write-back value select: 01 load, 10 link, anything else ALU
    always_comb begin
        case (in_wb_sel)
            2'b01:   w_wb_val = w_load_val;
            2'b10:   w_wb_val = in_pc_plus4;
            default: w_wb_val = in_alu_result;
        endcase
    end

    // x0 writes are folded into the stored strobe so the head and bypass see one qualified bit
    assign w_new_we     = in_wb_en && (in_rd != '0);
    assign w_head_valid = (r_state != S_EMPTY);
    assign w_push       = in_valid && r_in_ready;
    assign w_pop        = w_head_valid && (!r_head_we || rf_wr_ready);

    assign in_ready     = r_in_ready;
    assign rf_we        = w_head_valid && r_head_we;
    assign rf_waddr     = r_head_rd;
    assign rf_wdata     = r_head_data;
    assign retire_count = r_retire_cnt;

    // Occupancy state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Occupancy next state from push/pop
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: begin
                if (w_push) begin
                    w_state_nxt = S_ONE;
                end
            end
            S_ONE: begin
                if (w_push && !w_pop) begin
                    w_state_nxt = S_FULL;
                end else if (!w_push && w_pop) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_pop) begin
                    w_state_nxt = S_ONE;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // in_ready is registered from the next occupancy so it never depends on rf_wr_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready <= 1'b1;
        end else begin
            r_in_ready <= (w_state_nxt != S_FULL);
        end
    end

    // Queue storage: head feeds the write port, tail holds the second entry when full
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_we   <= 1'b0;
            r_head_rd   <= '0;
            r_head_data <= '0;
            r_tail_we   <= 1'b0;
            r_tail_rd   <= '0;
            r_tail_data <= '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_push) begin
                        r_head_we   <= w_new_we;
                        r_head_rd   <= in_rd;
                        r_head_data <= w_wb_val;
                    end
                end
                S_ONE: begin
                    if (w_push && w_pop) begin
                        r_head_we   <= w_new_we;
                        r_head_rd   <= in_rd;
                        r_head_data <= w_wb_val;
                    end else if (w_push) begin
                        r_tail_we   <= w_new_we;
                        r_tail_rd   <= in_rd;
                        r_tail_data <= w_wb_val;
                    end
                end
                S_FULL: begin
                    if (w_pop) begin
                        r_head_we   <= r_tail_we;
                        r_head_rd   <= r_tail_rd;
                        r_head_data <= r_tail_data;
                    end
                end
                default: begin
                    r_head_we <= 1'b0;
                end
            endcase
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retire_cnt <= '0;
        end else if (w_pop) begin
            r_retire_cnt <= r_retire_cnt + 1'b1;
        end
    end

`ifdef WB_STAGE_CTRL_BYPASS_EN
    // Bypass shows the youngest queued entry that will write a real register
    always_comb begin
        byp_valid = 1'b0;
        byp_rd    = r_head_rd;
        byp_data  = r_head_data;
        if ((r_state == S_FULL) && r_tail_we) begin
            byp_valid = 1'b1;
            byp_rd    = r_tail_rd;
            byp_data  = r_tail_data;
        end else if (w_head_valid && r_head_we) begin
            byp_valid = 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage_ctrl.sv
// tb/tb_wb_stage_ctrl.sv - randomized self-checking bench for wb_stage_ctrl
module tb_wb_stage_ctrl;

    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int CW   = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic            in_wb_en;
    logic [RW-1:0]   in_rd;
    logic [1:0]      in_wb_sel;
    logic [1:0]      in_mem_size;
    logic            in_mem_unsigned;
    logic [2:0]      in_addr_lo;
    logic [XLEN-1:0] in_mem_data;
    logic [XLEN-1:0] in_alu_result;
    logic [XLEN-1:0] in_pc_plus4;
    logic            rf_we;
    logic [RW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            rf_wr_ready;
    logic [CW-1:0]   retire_count;
`ifdef WB_STAGE_CTRL_BYPASS_EN
    logic            byp_valid;
    logic [RW-1:0]   byp_rd;
    logic [XLEN-1:0] byp_data;
`endif

    wb_stage_ctrl #(.XLEN(XLEN), .REG_ADDR_W(RW), .RETIRE_CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_wb_en        (in_wb_en),
        .in_rd           (in_rd),
        .in_wb_sel       (in_wb_sel),
        .in_mem_size     (in_mem_size),
        .in_mem_unsigned (in_mem_unsigned),
        .in_addr_lo      (in_addr_lo),
        .in_mem_data     (in_mem_data),
        .in_alu_result   (in_alu_result),
        .in_pc_plus4     (in_pc_plus4),
        .rf_we           (rf_we),
        .rf_waddr        (rf_waddr),
        .rf_wdata        (rf_wdata),
        .rf_wr_ready     (rf_wr_ready),
        .retire_count    (retire_count)
`ifdef WB_STAGE_CTRL_BYPASS_EN
        ,
        .byp_valid       (byp_valid),
        .byp_rd          (byp_rd),
        .byp_data        (byp_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            we;
        logic [RW-1:0]   rd;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t            m_q[$];
    logic [CW-1:0]   m_cnt;
    logic [RW-1:0]   m_last_addr;
    logic [XLEN-1:0] m_last_data;
    bit              m_pushed;
    int              n_vec = 0;
    int              n_err = 0;

    function automatic logic [XLEN-1:0] ref_format(input logic [1:0] sel, input logic [1:0] size,
                                                   input logic uns, input logic [2:0] lo,
                                                   input logic [XLEN-1:0] mem, input logic [XLEN-1:0] alu,
                                                   input logic [XLEN-1:0] pc);
        int          nbytes;
        int          lane;
        int          bits;
        logic [63:0] v;
        logic [63:0] m;
        if (sel == 2'b01) begin
            nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : ((XLEN == 64) ? 8 : 4);
            lane   = ((int'(lo) % (XLEN / 8)) / nbytes) * nbytes;
            v      = 64'(mem) >> (lane * 8);
            bits   = nbytes * 8;
            m      = (bits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
            v      = v & m;
            if (!uns && v[bits-1]) v = v | ~m;
            return v[XLEN-1:0];
        end else if (sel == 2'b10) begin
            return pc;
        end
        return alu;
    endfunction

    // Advances one clock and applies the queue rules to the reference model
    task automatic cycle();
        bit   push;
        bit   pop;
        ent_t e;
        @(posedge clk);
        push = 1'b0;
        if (rst) begin
            m_q.delete();
            m_cnt       = '0;
            m_last_addr = '0;
            m_last_data = '0;
        end else begin
            push = in_valid && (m_q.size() < 2);
            pop  = (m_q.size() > 0) && (!m_q[0].we || rf_wr_ready);
            if (pop) begin
                void'(m_q.pop_front());
                m_cnt = m_cnt + 1;
            end
            if (push) begin
                e.we   = in_wb_en && (in_rd != 0);
                e.rd   = in_rd;
                e.data = ref_format(in_wb_sel, in_mem_size, in_mem_unsigned, in_addr_lo,
                                    in_mem_data, in_alu_result, in_pc_plus4);
                m_q.push_back(e);
            end
            if (m_q.size() > 0) begin
                m_last_addr = m_q[0].rd;
                m_last_data = m_q[0].data;
            end
        end
        m_pushed = push;
        #1;
    endtask

    task automatic drive(input logic v, input logic wb, input logic [RW-1:0] rd, input logic [1:0] sel,
                         input logic [1:0] size, input logic uns, input logic [2:0] lo,
                         input logic [XLEN-1:0] mem, input logic [XLEN-1:0] alu, input logic [XLEN-1:0] pc);
        in_valid        = v;
        in_wb_en        = wb;
        in_rd           = rd;
        in_wb_sel       = sel;
        in_mem_size     = size;
        in_mem_unsigned = uns;
        in_addr_lo      = lo;
        in_mem_data     = mem;
        in_alu_result   = alu;
        in_pc_plus4     = pc;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rf_wr_ready = 1'b1;
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %0h want 1", in_ready); end
        n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_rf_we got %0h want 0", rf_we); end
        n_vec++; if (rf_waddr !== '0) begin n_err++; $display("FAIL reset_waddr got %0h want 0", rf_waddr); end
        n_vec++; if (rf_wdata !== '0) begin n_err++; $display("FAIL reset_wdata got %0h want 0", rf_wdata); end
        n_vec++; if (retire_count !== '0) begin n_err++; $display("FAIL reset_retire got %0h want 0", retire_count); end
    endtask

    task automatic test_alu_single();
        rf_wr_ready = 1'b1;
        drive(1, 1, 5, 2'b00, 0, 0, 0, 32'hDEAD_BEEF, 32'h1234_5678, 32'h4);
        cycle();
        in_valid = 1'b0;
        n_vec++; if (rf_we !== 1'b1) begin n_err++; $display("FAIL alu_rf_we got %0h want 1", rf_we); end
        n_vec++; if (rf_waddr !== 5'd5) begin n_err++; $display("FAIL alu_waddr got %0h want 5", rf_waddr); end
        n_vec++; if (rf_wdata !== 32'h1234_5678) begin n_err++; $display("FAIL alu_wdata got %0h want 12345678", rf_wdata); end
        cycle();
        n_vec++; if (retire_count !== 32'd1) begin n_err++; $display("FAIL alu_retire got %0h want 1", retire_count); end
        n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL alu_drained_we got %0h want 0", rf_we); end
    endtask

    task automatic test_load_format();
        logic [1:0]      sz  [3] = '{2'b00, 2'b00, 2'b01};
        logic            un  [3] = '{1'b0, 1'b1, 1'b0};
        logic [XLEN-1:0] mem [3] = '{32'h0080_0000, 32'h0080_0000, 32'h8001_0000};
        logic [XLEN-1:0] exp [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001};
        rf_wr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 2'b01, sz[i], un[i], 3'd2, mem[i], 32'h5555_5555, 32'h8);
            cycle();
            in_valid = 1'b0;
            n_vec++;
            if (rf_wdata !== exp[i]) begin
                n_err++; $display("FAIL load_fmt_%0d got %0h want %0h", i, rf_wdata, exp[i]);
            end
            cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] d [3];
        logic [CW-1:0]   base;
        base = m_cnt;
        for (int i = 0; i < 3; i++) d[i] = $urandom;
        rf_wr_ready = 1'b0;
        drive(1, 1, 10, 2'b00, 0, 0, 0, 0, d[0], 0);
        cycle();
        drive(1, 1, 11, 2'b00, 0, 0, 0, 0, d[1], 0);
        cycle();
        drive(1, 1, 12, 2'b00, 0, 0, 0, 0, d[2], 0);
        for (int k = 0; k < 3; k++) begin
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_stall_ready got %0h want 0", in_ready); end
            n_vec++; if (rf_we !== 1'b1) begin n_err++; $display("FAIL b2b_stall_we got %0h want 1", rf_we); end
            n_vec++; if (rf_waddr !== 5'd10 || rf_wdata !== d[0]) begin
                n_err++; $display("FAIL b2b_stall_head got %0h/%0h want a/%0h", rf_waddr, rf_wdata, d[0]);
            end
            cycle();
        end
        rf_wr_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            n_vec++;
            if (rf_we !== 1'b1 || rf_waddr !== RW'(10 + j) || rf_wdata !== d[j]) begin
                n_err++; $display("FAIL b2b_order_%0d got we=%0h %0h/%0h want 1 %0h/%0h", j, rf_we, rf_waddr, rf_wdata, 10 + j, d[j]);
            end
            cycle();
            if (m_pushed) in_valid = 1'b0;
        end
        n_vec++; if (retire_count !== base + 3) begin n_err++; $display("FAIL b2b_retire got %0h want %0h", retire_count, base + 3); end
        n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL b2b_drained_we got %0h want 0", rf_we); end
    endtask

    task automatic test_no_write();
        logic [CW-1:0] base;
        base = m_cnt;
        rf_wr_ready = 1'b0;
        drive(1, 1, 0, 2'b00, 0, 0, 0, 0, 32'hAAAA_0000, 0);
        cycle();
        n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL nowr_x0_we got %0h want 0", rf_we); end
        drive(1, 0, 9, 2'b00, 0, 0, 0, 0, 32'hBBBB_0000, 0);
        cycle();
        in_valid = 1'b0;
        n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL nowr_wben0_we got %0h want 0", rf_we); end
        n_vec++; if (retire_count !== base + 1) begin n_err++; $display("FAIL nowr_retire1 got %0h want %0h", retire_count, base + 1); end
        cycle();
        n_vec++; if (retire_count !== base + 2) begin n_err++; $display("FAIL nowr_retire2 got %0h want %0h", retire_count, base + 2); end
        n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL nowr_final_we got %0h want 0", rf_we); end
    endtask

    task automatic test_pc_reset();
        rf_wr_ready = 1'b1;
        drive(1, 1, 4, 2'b10, 0, 0, 0, 32'h1111_1111, 32'h2222_2222, 32'h0000_1004);
        cycle();
        in_valid = 1'b0;
        n_vec++; if (rf_wdata !== 32'h0000_1004) begin n_err++; $display("FAIL pc4_wdata got %0h want 1004", rf_wdata); end
        cycle();
        rf_wr_ready = 1'b0;
        drive(1, 1, 6, 2'b00, 0, 0, 0, 0, 32'h66, 0);
        cycle();
        drive(1, 1, 7, 2'b00, 0, 0, 0, 0, 32'h77, 0);
        cycle();
        in_valid = 1'b0;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got %0h want 0", in_ready); end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL rstmid_we got %0h want 0", rf_we); end
        n_vec++; if (retire_count !== '0) begin n_err++; $display("FAIL rstmid_retire got %0h want 0", retire_count); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got %0h want 1", in_ready); end
        n_vec++; if (rf_waddr !== '0 || rf_wdata !== '0) begin n_err++; $display("FAIL rstmid_port got %0h/%0h want 0/0", rf_waddr, rf_wdata); end
        rf_wr_ready = 1'b1;
        cycle();
        n_vec++; if (retire_count !== '0 || rf_we !== 1'b0) begin n_err++; $display("FAIL rstmid_nowrite got %0h/%0h want 0/0", retire_count, rf_we); end
    endtask

`ifdef WB_STAGE_CTRL_BYPASS_EN
    task automatic test_bypass();
        rf_wr_ready = 1'b0;
        drive(1, 1, 3, 2'b00, 0, 0, 0, 0, 32'h33, 0);
        cycle();
        drive(1, 1, 7, 2'b00, 0, 0, 0, 0, 32'h77, 0);
        cycle();
        in_valid = 1'b0;
        n_vec++; if (byp_valid !== 1'b1 || byp_rd !== 5'd7 || byp_data !== 32'h77) begin
            n_err++; $display("FAIL byp_tail got %0h/%0h/%0h want 1/7/77", byp_valid, byp_rd, byp_data);
        end
        rf_wr_ready = 1'b1;
        cycle();
        cycle();
        n_vec++; if (byp_valid !== 1'b0) begin n_err++; $display("FAIL byp_empty got %0h want 0", byp_valid); end
    endtask
`endif

    task automatic test_random();
        bit              exp_we;
        bit              exp_bv;
        logic [RW-1:0]   exp_brd;
        logic [XLEN-1:0] exp_bd;
        int              bad = 0;
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 99) < 2);
            rf_wr_ready = ($urandom_range(0, 99) < 60);
            drive($urandom_range(0, 99) < 70, $urandom_range(0, 3) != 0, RW'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                  2'($urandom), 2'($urandom), 1'($urandom), 3'($urandom), $urandom, $urandom, $urandom);
            exp_we = (m_q.size() > 0) && m_q[0].we;
            n_vec++;
            if (in_ready !== (m_q.size() < 2) || rf_we !== exp_we || rf_waddr !== m_last_addr ||
                rf_wdata !== m_last_data || retire_count !== m_cnt) begin
                n_err++;
                if (bad < 10) $display("FAIL rand_c%0d got rdy=%0h we=%0h %0h/%0h cnt=%0h want rdy=%0h we=%0h %0h/%0h cnt=%0h",
                                       c, in_ready, rf_we, rf_waddr, rf_wdata, retire_count,
                                       m_q.size() < 2, exp_we, m_last_addr, m_last_data, m_cnt);
                bad++;
            end
            exp_bv = 1'b0; exp_brd = '0; exp_bd = '0;
            for (int i = m_q.size() - 1; i >= 0; i--) begin
                if (!exp_bv && m_q[i].we) begin
                    exp_bv = 1'b1; exp_brd = m_q[i].rd; exp_bd = m_q[i].data;
                end
            end
`ifdef WB_STAGE_CTRL_BYPASS_EN
            n_vec++;
            if (byp_valid !== exp_bv || (exp_bv && (byp_rd !== exp_brd || byp_data !== exp_bd))) begin
                n_err++;
                if (bad < 10) $display("FAIL rand_byp_c%0d got %0h/%0h/%0h want %0h/%0h/%0h",
                                       c, byp_valid, byp_rd, byp_data, exp_bv, exp_brd, exp_bd);
                bad++;
            end
`endif
            cycle();
        end
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rf_wr_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_cnt = '0; m_last_addr = '0; m_last_data = '0; m_pushed = 1'b0;
        #1;
        test_reset();
        test_alu_single();
        test_load_format();
        test_back_to_back();
        test_no_write();
        test_pc_reset();
`ifdef WB_STAGE_CTRL_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
